packet_wrr_arbiter: RTL and testbench
=====================================

Name: packet_wrr_arbiter

Overview:
- N-channel packet arbiter with weighted round-robin (WRR) selection and parametrised data width.
- Grant is locked to one source for a whole packet (through the `last` beat).
- A source may keep the grant for up to `weight` consecutive packets before the pointer advances.
- Output is a registered slice that sits between per-source stream producers and a single shared downstream stream consumer.

Parameters:
- REQ_NUM, 8, number of input channels (>=2).
- DATA_WD, 32, data beat width.
- WT_WD, 4, width of each per-channel weight field.
- IDX_WD, $clog2(REQ_NUM), source index width (derived localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- cfg_weight  in  REQ_NUM*WT_WD  per-channel packet quota; channel i uses bits [i*WT_WD +: WT_WD].
- valid_in  in  REQ_NUM  per-channel beat valid.
- data_in  in  REQ_NUM*DATA_WD  per-channel beat data; channel i uses [i*DATA_WD +: DATA_WD].
- last_in  in  REQ_NUM  per-channel end-of-packet flag.
- ready_in  out  REQ_NUM  per-channel beat accept.
- valid_out  out  1  output beat valid (registered).
- data_out  out  DATA_WD  output beat data (registered).
- last_out  out  1  output end-of-packet (registered).
- src_out  out  IDX_WD  index of the channel that sourced the output beat (registered).
- ready_out  in  1  downstream accept.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE, owner=0, credit=0, rr_ptr=0.
  - valid_out=0, data_out=0, last_out=0, src_out=0, ready_in=0.
  - A packet in flight when reset asserts is dropped; no recovery is attempted.
- Round-robin pick (combinational):
  - Candidates are channels with valid_in high.
  - Priority goes to the lowest index >= rr_ptr; if none, the lowest index overall.
- Output slice:
  - slot_free = ~valid_out | ready_out.
  - ready_in[i] = (state==BUSY) & (owner==i) & slot_free. At most one bit is ever high.
  - beat accepted = valid_in[owner] & ready_in[owner].
  - When a beat is accepted, data_out/last_out/src_out/valid_out load on the next edge.
  - When valid_out & ready_out and no new beat is accepted, valid_out clears.
  - Input-to-output latency is 1 cycle.
  - Full throughput: 1 beat/cycle is sustained while ready_out=1.
- State machine, IDLE:
  - If any valid_in is high: owner<=pick, credit<=max(cfg_weight[pick],1)-1, state<=BUSY.
  - ready_in stays 0 in IDLE, so the first beat is accepted no earlier than the next cycle.
  - cfg_weight is sampled only at this grant point; changes mid-grant take effect at the next grant.
- State machine, BUSY, mid-packet:
  - The grant is held regardless of other valids.
  - If valid_in[owner] drops mid-packet, the arbiter waits; the grant is never pre-empted.
- State machine, BUSY, on an accepted beat with last_in=1:
  - If credit!=0: credit<=credit-1, stay BUSY with the same owner; boundary flag<=1.
  - If credit==0: rr_ptr<=owner+1 (wraps REQ_NUM-1 -> 0), state<=IDLE.
- State machine, BUSY with boundary flag=1 (between packets of a multi-packet grant):
  - If valid_in[owner]=0 in that cycle: release, rr_ptr<=owner+1, state<=IDLE.
  - Otherwise continue; the flag clears on the first accepted beat.
- Grant-switch cost: exactly one IDLE cycle between packets of different owners (bubble on ready_in, not necessarily on valid_out).
- Weight boundaries:
  - weight 0 is treated as 1.
  - weight 2^WT_WD-1 means at most that many consecutive packets.
- Simultaneous events:
  - A last beat accepted while ready_out=0 on the previous output beat cannot happen, because slot_free gates ready_in.
  - New valid_in on other channels during BUSY is ignored until IDLE.
- Single-beat packets (valid & last in the same beat) are legal.
- data_out holds its last value when valid_out=0. Verification must not check data_out then.

Decomposition:
- Shared package (pkt_arb_pkg): state encoding (IDLE, BUSY) and a helper function for the wrap increment of rr_ptr.
- Sub-module rr_pick: combinational pointer-based priority picker.
  - Inputs: reqs, ptr.
  - Outputs: one-hot grant, index, any.
  - Reusable by the existing arbiter family.
- Everything else (FSM, credit counter, output slice) lives in packet_wrr_arbiter.

Test Plan:
1. Reset mid-packet:
   - Stimulus: ch0 sends a 4-beat packet; rst pulses after beat 2.
   - Response: valid_out=0 and ready_in=0 immediately (async); after release, the arbiter re-arbitrates from rr_ptr=0.
2. Equal weights:
   - Stimulus: weights all 1, ch1/ch3/ch6 always valid with 2-beat packets.
   - Response: src_out sequence is 1,3,6,1,3,6 per packet, with one ready_in bubble cycle between packets.
3. Weighted grant:
   - Stimulus: cfg_weight ch2=3, ch5=1; both continuously valid with 1-beat packets.
   - Response: src_out pattern is 2,2,2,5,2,2,2,5.
4. Backpressure:
   - Stimulus: ready_out toggles 1,0,0,1 during a 5-beat packet from ch4.
   - Response: ready_in[4] is low whenever valid_out=1 and ready_out=0; beat order is preserved with no drop or duplicate; last_out appears on beat 5 only.
5. Early release:
   - Stimulus: ch0 weight=4 sends one packet, then valid_in[0]=0 at the boundary; ch7 is valid.
   - Response: the arbiter releases, rr_ptr=1, and ch7 is granted next.
6. Wrap and weight 0:
   - Stimulus: cfg_weight ch7=0; ch7 and ch0 valid; owner was ch7.
   - Response: ch7 gets exactly 1 packet, rr_ptr wraps to 0, and ch0 is granted next.

Source files
------------

// File: rtl/packet_wrr_arbiter_pkg.sv
// Shared types and helpers for the packet arbiter family.
package pkt_arb_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Next round-robin pointer position after idx, wrapping n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/packet_wrr_arbiter_if.sv
// Stream bundle between the per-source producers, the arbiter and the shared consumer.
interface packet_wrr_arbiter_if #(
  parameter int unsigned REQ_NUM = 8,
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned WT_WD   = 4
);
  localparam int unsigned IDX_WD = $clog2(REQ_NUM);

  logic [REQ_NUM*WT_WD-1:0]   cfg_weight;
  logic [REQ_NUM-1:0]         valid_in;
  logic [REQ_NUM*DATA_WD-1:0] data_in;
  logic [REQ_NUM-1:0]         last_in;
  logic [REQ_NUM-1:0]         ready_in;
  logic                       valid_out;
  logic [DATA_WD-1:0]         data_out;
  logic                       last_out;
  logic [IDX_WD-1:0]          src_out;
  logic                       ready_out;

  // Producer/consumer side.
  modport master (
    output cfg_weight, valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, last_out, src_out
  );

  // Arbiter side.
  modport slave (
    input  cfg_weight, valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, last_out, src_out
  );
endinterface

// File: rtl/packet_wrr_arbiter_rr_pick.sv
// Pointer-based priority picker: lowest requester at or above ptr, else lowest overall.
module rr_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         reqs_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0] masked;
  logic [N-1:0] cand;
  logic         found;

  // Mask off requesters below the pointer, fall back to the full set if none remain.
  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < N; i++) begin
      masked[i] = reqs_i[i] && (i >= 32'(ptr_i));
    end
    cand  = (|masked) ? masked : reqs_i;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i] && !found) begin
        idx_o = IW'(i);
        found = 1'b1;
      end
    end
    any_o = |reqs_i;
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/packet_wrr_arbiter.sv
// Weighted round-robin packet arbiter with a registered output slice.
module packet_wrr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM = 8,
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned WT_WD   = 4
) (
  input logic                 clk,
  input logic                 rst,
  packet_wrr_arbiter_if.slave bus_io
);
  localparam int unsigned IDX_WD = $clog2(REQ_NUM);

  arb_state_e        state_q, state_d;
  logic [IDX_WD-1:0] owner_q, owner_d;
  logic [WT_WD-1:0]  credit_q, credit_d;
  logic [IDX_WD-1:0] rr_ptr_q, rr_ptr_d;
  logic              bound_q, bound_d;
  logic              vld_q;
  logic [DATA_WD-1:0] data_q;
  logic              last_q;
  logic [IDX_WD-1:0] src_q;

  logic [WT_WD-1:0]   wt  [REQ_NUM];
  logic [DATA_WD-1:0] din [REQ_NUM];
  logic [REQ_NUM-1:0] pick_gnt;
  logic [IDX_WD-1:0]  pick_idx;
  logic               pick_any;
  logic [WT_WD-1:0]   pick_wt;
  logic [REQ_NUM-1:0] ready_in;
  logic               slot_free;
  logic               accept;

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
    assign wt[g]  = bus_io.cfg_weight[g*WT_WD +: WT_WD];
    assign din[g] = bus_io.data_in[g*DATA_WD +: DATA_WD];
  end

  rr_pick #(
    .N(REQ_NUM)
  ) u_pick (
    .reqs_i(bus_io.valid_in),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Weight of the picked channel, selected by the one-hot grant.
  always_comb begin
    pick_wt = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (pick_gnt[i]) pick_wt = pick_wt | wt[i];
    end
  end

  // Handshake: only the owner may push, and only when the output slot can take a beat.
  always_comb begin
    slot_free = ~vld_q | bus_io.ready_out;
    ready_in  = '0;
    if (state_q == StBusy && slot_free) ready_in[owner_q] = 1'b1;
    accept    = (state_q == StBusy) && slot_free && bus_io.valid_in[owner_q];
  end

  // Grant FSM and packet credit.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    rr_ptr_d = rr_ptr_q;
    bound_d  = bound_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          owner_d  = pick_idx;
          // Weight 0 behaves as 1: credit counts extra packets beyond the first.
          credit_d = (pick_wt == '0) ? '0 : pick_wt - WT_WD'(1);
          bound_d  = 1'b0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (bound_q && !bus_io.valid_in[owner_q]) begin
          // Owner has nothing ready between packets: give up the rest of its quota.
          rr_ptr_d = IDX_WD'(wrap_inc(32'(owner_q), REQ_NUM));
          bound_d  = 1'b0;
          state_d  = StIdle;
        end else if (accept) begin
          bound_d = 1'b0;
          if (bus_io.last_in[owner_q]) begin
            if (credit_q != '0) begin
              credit_d = credit_q - WT_WD'(1);
              bound_d  = 1'b1;
            end else begin
              rr_ptr_d = IDX_WD'(wrap_inc(32'(owner_q), REQ_NUM));
              state_d  = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      credit_q <= '0;
      rr_ptr_q <= '0;
      bound_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      rr_ptr_q <= rr_ptr_d;
      bound_q  <= bound_d;
    end
  end

  // Output slice: load on accept, drain when the consumer takes the beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      src_q  <= '0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      data_q <= din[owner_q];
      last_q <= bus_io.last_in[owner_q];
      src_q  <= owner_q;
    end else if (vld_q && bus_io.ready_out) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus_io.ready_in  = ready_in;
  assign bus_io.valid_out = vld_q;
  assign bus_io.data_out  = data_q;
  assign bus_io.last_out  = last_q;
  assign bus_io.src_out   = src_q;
endmodule

// File: tb/tb_packet_wrr_arbiter.sv
// Directed bench for packet_wrr_arbiter with simple per-channel packet producers.
module tb_packet_wrr_arbiter;
  localparam int unsigned REQ_NUM = 8;
  localparam int unsigned DATA_WD = 32;
  localparam int unsigned WT_WD   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  packet_wrr_arbiter_if #(.REQ_NUM(REQ_NUM), .DATA_WD(DATA_WD), .WT_WD(WT_WD)) bus ();

  packet_wrr_arbiter #(
    .REQ_NUM(REQ_NUM),
    .DATA_WD(DATA_WD),
    .WT_WD  (WT_WD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Producer model: channel c sends quota[c] packets of plen[c] beats.
  int plen  [REQ_NUM];
  int quota [REQ_NUM];
  int sent  [REQ_NUM];
  int beat  [REQ_NUM];

  int acc_cyc[$];
  int acc_ch [$];
  int pkt_src[$];
  logic [DATA_WD-1:0] out_data[$];
  logic out_last[$];
  int out_src[$];

  logic [3:0] ro_pat;
  bit   ro_rot;
  int   ro_k;
  bit   bp_check;
  int   bp_hits;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < REQ_NUM; c++) begin
      bus.valid_in[c] = (sent[c] < quota[c]);
      bus.last_in[c]  = (beat[c] == plen[c] - 1);
      bus.data_in[c*DATA_WD +: DATA_WD] = {8'(c), 8'(sent[c]), 16'(beat[c])};
    end
  endtask

  task automatic set_wt(input int c, input int w);
    bus.cfg_weight[c*WT_WD +: WT_WD] = WT_WD'(w);
  endtask

  task automatic clear_model();
    for (int c = 0; c < REQ_NUM; c++) begin
      plen[c] = 1; quota[c] = 0; sent[c] = 0; beat[c] = 0;
      set_wt(c, 1);
    end
    drive_inputs();
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); acc_ch.delete(); pkt_src.delete();
    out_data.delete(); out_last.delete(); out_src.delete();
  endtask

  // One clock: sample handshakes at negedge, advance producers after posedge.
  task automatic cycle();
    logic [REQ_NUM-1:0] acc;
    @(negedge clk);
    acc = bus.valid_in & bus.ready_in;
    check_eq("rdy_onehot", 64'($onehot0(bus.ready_in)), 64'd1);
    if (bp_check && bus.valid_out && !bus.ready_out) begin
      bp_hits++;
      check_eq("bp_hold", 64'(bus.ready_in), 64'd0);
    end
    for (int c = 0; c < REQ_NUM; c++) begin
      if (acc[c]) begin
        acc_cyc.push_back(cyc);
        acc_ch.push_back(c);
      end
    end
    if (bus.valid_out && bus.ready_out) begin
      out_data.push_back(bus.data_out);
      out_last.push_back(bus.last_out);
      out_src.push_back(int'(bus.src_out));
      if (bus.last_out) pkt_src.push_back(int'(bus.src_out));
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < REQ_NUM; c++) begin
      if (acc[c]) begin
        if (beat[c] == plen[c] - 1) begin
          beat[c] = 0;
          sent[c]++;
        end else begin
          beat[c]++;
        end
      end
    end
    if (ro_rot) begin
      bus.ready_out = ro_pat[ro_k];
      ro_k = (ro_k + 1) % 4;
    end
    drive_inputs();
  endtask

  task automatic run_pkts(input string tag, input int n);
    int k = 0;
    while (pkt_src.size() < n && k < 300) begin
      cycle();
      k++;
    end
    check_eq({tag, "_done"}, 64'(pkt_src.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    int exp2[6] = '{1, 3, 6, 1, 3, 6};
    int exp3[8] = '{2, 2, 2, 5, 2, 2, 2, 5};
    int k;

    rst = 1'b1;
    bus.ready_out = 1'b1;
    ro_rot = 0; ro_k = 0; ro_pat = 4'b1001; bp_check = 0; bp_hits = 0;
    clear_model();
    #1;
    check_eq("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check_eq("rst_ready_in", 64'(bus.ready_in), 64'd0);
    check_eq("rst_last_out", 64'(bus.last_out), 64'd0);
    check_eq("rst_src_out", 64'(bus.src_out), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();

    // Equal weights, ch1/3/6 with 2-beat packets.
    plen[1] = 2; plen[3] = 2; plen[6] = 2;
    quota[1] = 2; quota[3] = 2; quota[6] = 2;
    drive_inputs();
    run_pkts("t2", 6);
    for (int i = 0; i < 6; i++) check_eq($sformatf("t2_src%0d", i), 64'(pkt_src[i]), 64'(exp2[i]));
    check_eq("t2_back2back", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
    check_eq("t2_bubble", 64'(acc_cyc[2] - acc_cyc[1]), 64'd2);

    // Reset mid-packet; rr_ptr was left at 7 by the previous run.
    clear_logs();
    plen[0] = 4; quota[0] = 1;
    drive_inputs();
    k = 0;
    while (acc_ch.size() < 2 && k < 30) begin
      cycle();
      k++;
    end
    check_eq("t1_two_beats", 64'(acc_ch.size()), 64'd2);
    rst = 1'b1;
    #1;
    check_eq("t1_async_valid_out", 64'(bus.valid_out), 64'd0);
    check_eq("t1_async_ready_in", 64'(bus.ready_in), 64'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    quota[6] = 1; quota[7] = 1;
    drive_inputs();
    run_pkts("t1", 2);
    check_eq("t1_first", 64'(pkt_src[0]), 64'd6);
    check_eq("t1_second", 64'(pkt_src[1]), 64'd7);

    // Weighted grant: ch2 weight 3, ch5 weight 1, single-beat packets.
    do_reset();
    set_wt(2, 3); set_wt(5, 1);
    quota[2] = 6; quota[5] = 2;
    drive_inputs();
    run_pkts("t3", 8);
    for (int i = 0; i < 8; i++) check_eq($sformatf("t3_src%0d", i), 64'(pkt_src[i]), 64'(exp3[i]));
    check_eq("t3_no_bubble", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);

    // Backpressure on a 5-beat packet from ch4.
    do_reset();
    plen[4] = 5; quota[4] = 1;
    ro_rot = 1; ro_k = 0; bp_check = 1; bp_hits = 0;
    drive_inputs();
    run_pkts("t4", 1);
    ro_rot = 0; bp_check = 0;
    bus.ready_out = 1'b1;
    check_eq("t4_bp_seen", 64'(bp_hits > 0), 64'd1);
    check_eq("t4_beats", 64'(out_data.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      logic [DATA_WD-1:0] exp_d;
      exp_d = {8'd4, 8'd0, 16'(i)};
      check_eq($sformatf("t4_data%0d", i), 64'(out_data[i]), 64'(exp_d));
      check_eq($sformatf("t4_last%0d", i), 64'(out_last[i]), 64'(i == 4));
      check_eq($sformatf("t4_src%0d", i), 64'(out_src[i]), 64'd4);
    end

    // Early release: ch0 weight 4 sends one packet then goes idle.
    do_reset();
    set_wt(0, 4);
    plen[0] = 2; quota[0] = 1; quota[7] = 1;
    drive_inputs();
    run_pkts("t5", 2);
    check_eq("t5_first", 64'(pkt_src[0]), 64'd0);
    check_eq("t5_second", 64'(pkt_src[1]), 64'd7);
    check_eq("t5_release_gap", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);

    // Weight 0 on ch7 with pointer wrap back to ch0.
    do_reset();
    set_wt(7, 0);
    quota[6] = 1;
    drive_inputs();
    k = 0;
    while (sent[6] < 1 && k < 30) begin
      cycle();
      k++;
    end
    check_eq("t6_ch6_sent", 64'(sent[6]), 64'd1);
    quota[7] = 2; quota[0] = 1;
    drive_inputs();
    run_pkts("t6", 4);
    check_eq("t6_src0", 64'(pkt_src[0]), 64'd6);
    check_eq("t6_src1", 64'(pkt_src[1]), 64'd7);
    check_eq("t6_src2", 64'(pkt_src[2]), 64'd0);
    check_eq("t6_src3", 64'(pkt_src[3]), 64'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
